// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter stage (seconds/minutes/hours).
// Counts 0..MODULUS-1 on tick, with parallel load (range checked), manual
// per-digit setting, a registered carry on up-wrap and a terminal-count flag.
// Optional build macro CNT_DOWN_EN adds the dir input (1 = count down) and
// a registered borrow pulse on down-wrap.
//
// Strobe semantics: tick, set_l, set_h and load are single-cycle pulses with
// no ready/back-pressure; each is sampled on the rising clk edge. When several
// are high on one edge only the highest priority one (load > set_l > set_h >
// tick) acts, and the others are dropped rather than queued.
module bcd_mod_counter #(
    parameter int         MODULUS = 60,
    parameter logic [3:0] INIT_L  = 4'd0,
    parameter logic [3:0] INIT_H  = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_l,
    input  logic       set_h,
    input  logic       load,
    input  logic [7:0] load_val,
`ifdef CNT_DOWN_EN
    input  logic       dir,
    output logic       borrow,
`endif
    output logic [3:0] cnt_l,
    output logic [3:0] cnt_h,
    output logic       carry,
    output logic       at_max,
    output logic       load_err
);

    // Modulus arithmetic is done on the binary value 10*tens + units (max 109).
    localparam logic [7:0] MOD_V = 8'(MODULUS);
    localparam logic [7:0] MAX_V = 8'(MODULUS - 1);
    localparam logic [3:0] MAX_L = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] MAX_H = 4'((MODULUS - 1) / 10);

    logic [7:0] cur_v;
    logic [7:0] load_v;
    logic [7:0] set_l_v;
    logic [7:0] set_h_v;
    logic       load_ok;
    logic       set_l_wrap;
    logic       set_h_wrap;
    logic       is_max;
    logic       is_zero;

    // Binary view of the current and candidate values plus range decisions.
    always_comb begin
        cur_v      = 8'(cnt_h) * 8'd10 + 8'(cnt_l);
        load_v     = 8'(load_val[7:4]) * 8'd10 + 8'(load_val[3:0]);
        load_ok    = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                     (load_v < MOD_V);
        set_l_v    = cur_v + 8'd1;
        set_l_wrap = (cnt_l == 4'd9) || (set_l_v >= MOD_V);
        set_h_v    = cur_v + 8'd10;
        set_h_wrap = (set_h_v >= MOD_V);
        is_max     = (cur_v == MAX_V);
        is_zero    = (cur_v == 8'd0);
    end

    // Terminal count follows the counting direction so a down-counting chain
    // sees the flag at 00 just like an up-counting chain sees it at MODULUS-1.
`ifdef CNT_DOWN_EN
    assign at_max = dir ? is_zero : is_max;
`else
    assign at_max = is_max;
`endif

    // Counter state and one-cycle status pulses, prioritised load > set_l > set_h > tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_l    <= INIT_L;
            cnt_h    <= INIT_H;
            carry    <= 1'b0;
            load_err <= 1'b0;
`ifdef CNT_DOWN_EN
            borrow   <= 1'b0;
`endif
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
`ifdef CNT_DOWN_EN
            borrow   <= 1'b0;
`endif
            if (load) begin
                if (load_ok) begin
                    cnt_h <= load_val[7:4];
                    cnt_l <= load_val[3:0];
                end else begin
                    load_err <= 1'b1;
                end
            end else if (set_l) begin
                cnt_l <= set_l_wrap ? 4'd0 : cnt_l + 4'd1;
            end else if (set_h) begin
                cnt_h <= set_h_wrap ? 4'd0 : cnt_h + 4'd1;
            end else if (tick) begin
`ifdef CNT_DOWN_EN
                if (dir) begin
                    if (is_zero) begin
                        cnt_h  <= MAX_H;
                        cnt_l  <= MAX_L;
                        borrow <= 1'b1;
                    end else if (cnt_l == 4'd0) begin
                        cnt_l <= 4'd9;
                        cnt_h <= cnt_h - 4'd1;
                    end else begin
                        cnt_l <= cnt_l - 4'd1;
                    end
                end else
`endif
                begin
                    if (is_max) begin
                        cnt_h <= 4'd0;
                        cnt_l <= 4'd0;
                        carry <= 1'b1;
                    end else if (cnt_l == 4'd9) begin
                        cnt_l <= 4'd0;
                        cnt_h <= cnt_h + 4'd1;
                    end else begin
                        cnt_l <= cnt_l + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: three counter stages (MODULUS 60/24/2) share one
// stimulus stream; an integer reference model per stage predicts each cycle.
// Build with +define+CNT_DOWN_EN to include the down-count section.
module tb_bcd_mod_counter;

    localparam int E = 12;      // per-stage packed observation width
    localparam int W = 3 * E;   // one scoreboard entry covers all three stages

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       set_l = 1'b0;
    logic       set_h = 1'b0;
    logic       load = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [3:0] cl [3];
    logic [3:0] ch [3];
    logic       cy [3];
    logic       am [3];
    logic       le [3];
    logic       bw [3];

    int mods  [3] = '{60, 24, 2};
    int inits [3] = '{58, 0, 0};
    int mv    [3];

    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    bcd_mod_counter #(.MODULUS(60), .INIT_L(4'd8), .INIT_H(4'd5)) u_m60 (
        .clk(clk), .rst(rst), .tick(tick), .set_l(set_l), .set_h(set_h),
        .load(load), .load_val(load_val),
`ifdef CNT_DOWN_EN
        .dir(dir), .borrow(bw[0]),
`endif
        .cnt_l(cl[0]), .cnt_h(ch[0]), .carry(cy[0]), .at_max(am[0]), .load_err(le[0])
    );

    bcd_mod_counter #(.MODULUS(24), .INIT_L(4'd0), .INIT_H(4'd0)) u_m24 (
        .clk(clk), .rst(rst), .tick(tick), .set_l(set_l), .set_h(set_h),
        .load(load), .load_val(load_val),
`ifdef CNT_DOWN_EN
        .dir(dir), .borrow(bw[1]),
`endif
        .cnt_l(cl[1]), .cnt_h(ch[1]), .carry(cy[1]), .at_max(am[1]), .load_err(le[1])
    );

    bcd_mod_counter #(.MODULUS(2), .INIT_L(4'd0), .INIT_H(4'd0)) u_m2 (
        .clk(clk), .rst(rst), .tick(tick), .set_l(set_l), .set_h(set_h),
        .load(load), .load_val(load_val),
`ifdef CNT_DOWN_EN
        .dir(dir), .borrow(bw[2]),
`endif
        .cnt_l(cl[2]), .cnt_h(ch[2]), .carry(cy[2]), .at_max(am[2]), .load_err(le[2])
    );

`ifndef CNT_DOWN_EN
    assign bw[0] = 1'b0;
    assign bw[1] = 1'b0;
    assign bw[2] = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Works on the plain integer value; digits are derived only when packing.
    function automatic void model_step(input int m, inout int v, input bit ld,
                                       input logic [7:0] lv, input bit sl, input bit sh,
                                       input bit tk, input bit dr,
                                       output bit c, output bit lerr, output bit b);
        int u;
        int t;
        int lu;
        int lt;
        c = 1'b0;
        lerr = 1'b0;
        b = 1'b0;
        u = v % 10;
        t = v / 10;
        lu = int'(lv[3:0]);
        lt = int'(lv[7:4]);
        if (ld) begin
            if (lu <= 9 && lt <= 9 && (lt * 10 + lu) < m) v = lt * 10 + lu;
            else lerr = 1'b1;
        end else if (sl) begin
            if (u == 9 || (t * 10 + u + 1) >= m) u = 0;
            else u = u + 1;
            v = t * 10 + u;
        end else if (sh) begin
            if (((t + 1) * 10 + u) >= m) t = 0;
            else t = t + 1;
            v = t * 10 + u;
        end else if (tk) begin
            if (dr) begin
                if (v == 0) begin
                    v = m - 1;
                    b = 1'b1;
                end else begin
                    v = v - 1;
                end
            end else begin
                if (v == m - 1) begin
                    v = 0;
                    c = 1'b1;
                end else begin
                    v = v + 1;
                end
            end
        end
    endfunction

    function automatic logic [E-1:0] pack_exp(input int v, input bit c, input bit lerr,
                                              input bit b, input int m, input bit dr);
        logic [3:0] th;
        logic [3:0] un;
        bit         tc;
        th = 4'(v / 10);
        un = 4'(v % 10);
        tc = dr ? (v == 0) : (v == m - 1);
        return {th, un, c, lerr, b, tc};
    endfunction

    function automatic logic [E-1:0] observed(input int i);
        return {ch[i], cl[i], cy[i], le[i], bw[i], am[i]};
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [E-1:0] got, input logic [E-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {h,l,c,le,b,tc}=%h required %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("m%0d", mods[i]), observed(i), e[i*E +: E]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit ld, input logic [7:0] lv, input bit sl, input bit sh, input bit tk);
        logic [W-1:0] e;
        bit c;
        bit lerr;
        bit b;
        @(negedge clk);
        load = ld;
        load_val = lv;
        set_l = sl;
        set_h = sh;
        tick = tk;
        for (int i = 0; i < 3; i++) begin
            model_step(mods[i], mv[i], ld, lv, sl, sh, tk, dir, c, lerr, b);
            e[i*E +: E] = pack_exp(mv[i], c, lerr, b, mods[i], dir);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic clear_inputs();
        load = 1'b0;
        set_l = 1'b0;
        set_h = 1'b0;
        tick = 1'b0;
        load_val = 8'h00;
    endtask

    // Reset asserted between edges, with strobes still active from the last step.
    task automatic async_reset();
        #2;
        load = 1'b1;
        load_val = 8'h11;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) mv[i] = inits[i];
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("async_rst_m%0d", mods[i]), observed(i),
                     pack_exp(mv[i], 1'b0, 1'b0, 1'b0, mods[i], dir));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("rst_hold_m%0d", mods[i]), observed(i),
                     pack_exp(mv[i], 1'b0, 1'b0, 1'b0, mods[i], dir));
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) mv[i] = inits[i];
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m60_const", observed(0), 12'h580);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("rst_m%0d", mods[i]), observed(i),
                     pack_exp(mv[i], 1'b0, 1'b0, 1'b0, mods[i], 1'b0));
        @(negedge clk);
        rst = 1'b0;

        // 58 -> 59 -> 00 (carry) -> 01 on the MODULUS=60 stage
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // load / set behaviour (MODULUS=24 examples)
        step(1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("m24_set_h_19_to_09", observed(1), 12'h090);
        step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // priority: load beats set_l and tick; set_l beats tick
        step(1'b1, 8'h10, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // counting at 37 when reset hits between edges
        step(1'b1, 8'h36, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        async_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // back-to-back ticks (MODULUS=2 wraps every other edge)
        repeat (6) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // random mix
        for (int n = 0; n < 400; n++) begin
            logic [7:0] lv;
            bit ld;
            bit sl;
            bit sh;
            bit tk;
            ld = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            sl = ($urandom_range(0, 7) == 0);
            sh = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 2) != 0);
            step(ld, lv, sl, sh, tk);
        end

`ifdef CNT_DOWN_EN
        dir = 1'b1;
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            dir = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 9) == 0), {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
        end
`endif

        @(negedge clk);
        clear_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
